// File: rtl/mem_resp_ctrl_if.sv
// Core-side request/response bundle for mem_resp_ctrl.
// The byte-enable lane exists only when MEM_RESP_BYTE_EN is defined.
interface mem_resp_ctrl_if #(
    parameter int WL = 32
);
    logic          req;
    logic          wr;
    logic [31:0]   addr;
    logic [WL-1:0] wdata;
`ifdef MEM_RESP_BYTE_EN
    logic [3:0]    be;
`endif
    logic [WL-1:0] rdata;
    logic          ack;
    logic          busy;
    logic          err;

`ifdef MEM_RESP_BYTE_EN
    modport master (
        output req, wr, addr, wdata, be,
        input  rdata, ack, busy, err
    );
    modport slave (
        input  req, wr, addr, wdata, be,
        output rdata, ack, busy, err
    );
`else
    modport master (
        output req, wr, addr, wdata,
        input  rdata, ack, busy, err
    );
    modport slave (
        input  req, wr, addr, wdata,
        output rdata, ack, busy, err
    );
`endif
endinterface

// File: rtl/mem_resp_ctrl.sv
// Single-request memory responder with WAIT wait states before a one-cycle ACK.
// Define MEM_RESP_BYTE_EN to enable per-byte write masking through bus.be.
module mem_resp_ctrl #(
    parameter int WL         = 32,
    parameter int DEPTH_LOG2 = 8,
    parameter int WAIT       = 2
) (
    input logic            clk,
    input logic            rst_n,
    mem_resp_ctrl_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = (WAIT < 1) ? 1 : $clog2(WAIT + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic [WL-1:0]         mem [DEPTH];

    logic                  wr_q;
    logic                  fault_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [WL-1:0]         wdata_q;
`ifdef MEM_RESP_BYTE_EN
    logic [3:0]            be_q;
`endif

    logic                  ack_q;
    logic                  busy_q;
    logic                  err_q;
    logic [WL-1:0]         rdata_q;

    logic                  req_fault;
    logic [DEPTH_LOG2-1:0] req_idx;

    // Misaligned or beyond the storage window; decided once, at capture.
    assign req_fault = (bus.addr[1:0] != 2'b00) || (bus.addr[31:DEPTH_LOG2+2] != '0);
    assign req_idx   = bus.addr[DEPTH_LOG2+1:2];

    assign bus.ack   = ack_q;
    assign bus.busy  = busy_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            fault_q <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
`ifdef MEM_RESP_BYTE_EN
            be_q    <= '0;
`endif
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        wr_q    <= bus.wr;
                        fault_q <= req_fault;
                        idx_q   <= req_idx;
                        wdata_q <= bus.wdata;
`ifdef MEM_RESP_BYTE_EN
                        be_q    <= bus.be;
`endif
                        cnt     <= CW'(WAIT);
                        busy_q  <= 1'b1;
                        // With no wait states the response is formed straight from the request.
                        if (WAIT == 0) begin
                            state   <= ST_RESP;
                            ack_q   <= 1'b1;
                            err_q   <= req_fault;
                            rdata_q <= (!bus.wr && !req_fault) ? mem[req_idx] : '0;
                        end else begin
                            state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state   <= ST_RESP;
                        ack_q   <= 1'b1;
                        err_q   <= fault_q;
                        rdata_q <= (!wr_q && !fault_q) ? mem[idx_q] : '0;
                    end
                end
                ST_RESP: begin
                    state   <= ST_IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state   <= ST_IDLE;
                    ack_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
            endcase
        end
    end

    // Writes land on the edge leaving RESP, so a reset during WAIT drops them.
    always_ff @(posedge clk) begin
        if (state == ST_RESP && wr_q && !fault_q) begin
`ifdef MEM_RESP_BYTE_EN
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
`else
            mem[idx_q] <= wdata_q;
`endif
        end
    end
endmodule

// File: tb/tb_mem_resp_ctrl.sv
// Directed checks for mem_resp_ctrl: one instance with WAIT=2, one with WAIT=0.
// Byte-enable vectors run only when MEM_RESP_BYTE_EN is defined.
module tb_mem_resp_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mem_resp_ctrl_if #(.WL(32)) bus ();
    mem_resp_ctrl_if #(.WL(32)) bus0 ();

    mem_resp_ctrl #(.WL(32), .DEPTH_LOG2(8), .WAIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mem_resp_ctrl #(.WL(32), .DEPTH_LOG2(8), .WAIT(0)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus0)
    );

    int          totalChecks = 0;
    int          badChecks   = 0;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          busyCyc;
    int          ackCount;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Issues one request on the WAIT=2 instance and returns at the negedge of its ACK cycle.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 output logic [31:0] rdOut, output logic errOut,
                                 output int latOut, output int busyOut);
        int cyc;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.wr    = w;
        bus.addr  = a;
        bus.wdata = d;
        @(negedge clk);
        bus.req = 1'b0;
        cyc     = 1;
        busyOut = 0;
        while (bus.ack !== 1'b1 && cyc < 20) begin
            if (bus.busy === 1'b1) busyOut++;
            @(negedge clk);
            cyc++;
        end
        if (bus.busy === 1'b1) busyOut++;
        latOut = cyc;
        rdOut  = bus.rdata;
        errOut = bus.err;
    endtask

    initial begin
        bus.req    = 1'b0;
        bus.wr     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        bus0.req   = 1'b0;
        bus0.wr    = 1'b0;
        bus0.addr  = '0;
        bus0.wdata = '0;
`ifdef MEM_RESP_BYTE_EN
        bus.be     = 4'hF;
        bus0.be    = 4'hF;
`endif
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rstAck",   32'(bus.ack),  32'd0);
        checkOutput("rstBusy",  32'(bus.busy), 32'd0);
        checkOutput("rstErr",   32'(bus.err),  32'd0);
        checkOutput("rstRdata", bus.rdata,     32'd0);
        checkOutput("rstAck0",  32'(bus0.ack), 32'd0);
        rst_n = 1'b1;

        // Basic write then read-after-write, WAIT=2
        applyStimulus(1'b1, 32'h10, 32'hDEADBEEF, rd, er, lat, busyCyc);
        checkOutput("wrLat",  32'(lat),     32'd3);
        checkOutput("wrBusy", 32'(busyCyc), 32'd3);
        checkOutput("wrErr",  32'(er),      32'd0);
        @(negedge clk);
        checkOutput("ackDrop",  32'(bus.ack),  32'd0);
        checkOutput("busyDrop", 32'(bus.busy), 32'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, rd, er, lat, busyCyc);
        checkOutput("rdLat",  32'(lat),     32'd3);
        checkOutput("rdBusy", 32'(busyCyc), 32'd3);
        checkOutput("rdData", rd,           32'hDEADBEEF);
        checkOutput("rdErr",  32'(er),      32'd0);

        // Reset during WAIT discards the pending write
        @(negedge clk);
        bus.req   = 1'b1;
        bus.wr    = 1'b1;
        bus.addr  = 32'h10;
        bus.wdata = 32'hCAFEF00D;
        @(negedge clk);
        bus.req = 1'b0;
        checkOutput("abortBusyBefore", 32'(bus.busy), 32'd1);
        #1 rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abortBusyReset", 32'(bus.busy), 32'd0);
        rst_n    = 1'b1;
        ackCount = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.ack === 1'b1) ackCount++;
        end
        checkOutput("abortNoAck", 32'(ackCount), 32'd0);
        applyStimulus(1'b0, 32'h10, 32'h0, rd, er, lat, busyCyc);
        checkOutput("abortKeep", rd, 32'hDEADBEEF);

        // Faults: misaligned, out of range, faulting write leaves storage untouched
        applyStimulus(1'b1, 32'h0, 32'h12345678, rd, er, lat, busyCyc);
        checkOutput("w0Err", 32'(er), 32'd0);
        applyStimulus(1'b0, 32'h13, 32'h0, rd, er, lat, busyCyc);
        checkOutput("misErr",  32'(er), 32'd1);
        checkOutput("misData", rd,      32'd0);
        checkOutput("misLat",  32'(lat), 32'd3);
        applyStimulus(1'b0, 32'h400, 32'h0, rd, er, lat, busyCyc);
        checkOutput("oorErr",  32'(er), 32'd1);
        checkOutput("oorData", rd,      32'd0);
        applyStimulus(1'b1, 32'h402, 32'hFFFFFFFF, rd, er, lat, busyCyc);
        checkOutput("badWrErr", 32'(er), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, rd, er, lat, busyCyc);
        checkOutput("word0Kept", rd,      32'h12345678);
        checkOutput("word0Err",  32'(er), 32'd0);

        // A request pulsed while busy is dropped
        applyStimulus(1'b1, 32'h20, 32'h0BADF00D, rd, er, lat, busyCyc);
        @(negedge clk);
        bus.req  = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = 32'h10;
        @(negedge clk);
        bus.req   = 1'b1;
        bus.wr    = 1'b1;
        bus.addr  = 32'h20;
        bus.wdata = 32'h55;
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        checkOutput("ignAck",  32'(bus.ack), 32'd1);
        checkOutput("ignData", bus.rdata,    32'hDEADBEEF);
        @(negedge clk);
        checkOutput("ignIdle", 32'(bus.busy), 32'd0);
        applyStimulus(1'b0, 32'h20, 32'h0, rd, er, lat, busyCyc);
        checkOutput("ignKeep", rd, 32'h0BADF00D);

`ifdef MEM_RESP_BYTE_EN
        // Byte-lane merge and the all-zero mask
        applyStimulus(1'b1, 32'h8, 32'h11223344, rd, er, lat, busyCyc);
        bus.be = 4'b0101;
        applyStimulus(1'b1, 32'h8, 32'hAABBCCDD, rd, er, lat, busyCyc);
        bus.be = 4'b0000;
        applyStimulus(1'b1, 32'h8, 32'hFFFFFFFF, rd, er, lat, busyCyc);
        checkOutput("beZeroErr", 32'(er), 32'd0);
        bus.be = 4'hF;
        applyStimulus(1'b0, 32'h8, 32'h0, rd, er, lat, busyCyc);
        checkOutput("beMerge", rd, 32'h11BB33DD);
`endif

        // WAIT=0 instance: ACK the cycle after acceptance, streaming every 2 cycles
        @(negedge clk);
        bus0.req   = 1'b1;
        bus0.wr    = 1'b1;
        bus0.addr  = 32'h10;
        bus0.wdata = 32'h600DCAFE;
        @(negedge clk);
        bus0.req = 1'b0;
        checkOutput("z0WrAck",  32'(bus0.ack),  32'd1);
        checkOutput("z0WrErr",  32'(bus0.err),  32'd0);
        checkOutput("z0WrBusy", 32'(bus0.busy), 32'd1);
        @(negedge clk);
        checkOutput("z0AckDrop",  32'(bus0.ack),  32'd0);
        checkOutput("z0BusyDrop", 32'(bus0.busy), 32'd0);
        bus0.req = 1'b1;
        bus0.wr  = 1'b0;
        @(negedge clk);
        checkOutput("z0RdAck",  32'(bus0.ack), 32'd1);
        checkOutput("z0RdData", bus0.rdata,    32'h600DCAFE);
        ackCount = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus0.ack === 1'b1) ackCount++;
        end
        bus0.req = 1'b0;
        checkOutput("z0Stream", 32'(ackCount), 32'd4);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end
endmodule

// File: doc/mem_resp_ctrl.md
Name: mem_resp_ctrl

Overview:
Memory responder for the multi-cycle core's unified instruction/data port. It accepts one request at a time from the processor using a REQ/ACK handshake. It then serves a word read or write from internal storage after a configurable number of wait states. It replaces the zero-latency RAM so that the core's control FSM can be exercised against real memory latency.

Parameters:
WL, 32, data word width in bits
DEPTH_LOG2, 8, log2 of storage depth in words (256 words)
WAIT, 2, wait-state cycles between acceptance and ACK (0 allowed)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous, active-low reset
REQ  in  1  request strobe from core; sampled only in IDLE
WR  in  1  1 = write, 0 = read; captured with REQ
ADDR  in  32  byte address; captured with REQ
WDATA  in  WL  write data; captured with REQ
RDATA  out  WL  read data; valid only while ACK=1
ACK  out  1  one-cycle completion pulse
BUSY  out  1  high from acceptance through the ACK cycle
ERR  out  1  high with ACK when the request faulted

Behaviour:
- Reset (RST=0, asynchronous):
  - Forces state to IDLE.
  - ACK=0, BUSY=0, ERR=0, RDATA=0, wait counter=0.
  - Storage contents are not cleared.
  - Any in-flight request is discarded; a pending write does not occur.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If REQ=1 at a rising edge, latch WR, ADDR, WDATA and load the counter with WAIT.
  - Go to WAIT if WAIT>0, else to RESP.
  - BUSY goes high on that same edge.
- WAIT: decrement the counter each cycle. When the counter reaches 1, the next state is RESP. Exactly WAIT cycles are spent in WAIT.
- RESP (exactly one cycle):
  - ACK=1, BUSY=1.
  - RDATA = mem[word index] for a valid read, 0 otherwise.
  - A valid write commits to storage on the edge leaving RESP.
  - Next state is IDLE; ACK drops to 0.
- Latency: with the request accepted at edge 0, ACK is high during cycle WAIT+1. With WAIT=2, ACK is high in the 3rd cycle after acceptance.
- REQ is ignored while BUSY=1, including during the ACK cycle. The earliest next acceptance is the edge after the ACK cycle (IDLE). A request held high continuously is therefore re-accepted every WAIT+2 cycles.
- Word index = captured ADDR[DEPTH_LOG2+1:2].
- Faults (ERR=1 alongside ACK, no storage write, RDATA=0):
  - misaligned: ADDR[1:0] != 0
  - out of range: ADDR[31:DEPTH_LOG2+2] != 0
- Read of a word never written returns X in simulation; no initialisation is required.
- ACK, ERR and RDATA are registered outputs (no combinational path from inputs).
- Read-after-write to the same address in consecutive requests returns the new data.

Optional Feature:
Macro MEM_RESP_BYTE_EN.
- Defined: adds input BE [3:0], captured with REQ. A write updates only the bytes whose BE bit is 1 (BE[0] = bits 7:0). BE=4'b0000 writes nothing, but the request still ACKs with ERR=0. Reads ignore BE.
- Undefined: no BE port; every write updates the full word.

Test Plan:
- Reset mid-operation: write request to 0x10 accepted, RST pulsed low during WAIT -> ACK never asserts; a subsequent read of 0x10 returns the prior contents, not the aborted data.
- Basic write/read, WAIT=2: write 0xDEADBEEF to 0x00000010, then read 0x10 -> each ACK occurs exactly 3 cycles after acceptance; RDATA=0xDEADBEEF with ERR=0; BUSY high for 3 cycles per request.
- Zero wait: WAIT=0, read 0x10 -> ACK in the cycle immediately after acceptance. REQ held high -> acceptances every 2 cycles.
- Faults: read 0x00000013 and read 0x00000400 (DEPTH_LOG2=8) -> ERR=1 with ACK, RDATA=0. Write 0x0000_0402 -> ERR=1 and a later read of word 0 is unchanged.
- Busy ignore: pulse REQ (write 0x55 to 0x20) during another request's WAIT -> that pulse is dropped; read 0x20 returns the old value.
- Byte enable (MEM_RESP_BYTE_EN): word 0x8 = 0x11223344, write 0xAABBCCDD with BE=4'b0101 -> read returns 0x11BB33DD.
